ysyx_25040109_clint: RTL and testbench
======================================

Name: ysyx_25040109_clint

Overview:
- AXI subordinate (responder) for the core-local timer, at 0x1001_0000 (mtime low) and 0x1001_0004 (mtime high).
- Sits on the crossbar's CLINT port, behind the c_* channel set.
- Owns a free-running 64-bit mtime counter. Returns it on the AR/R channels with id and rlast.
- Completes every write with a B response.

Parameters:
- RD_LAT, 1: cycles from AR handshake to rvalid assertion. Legal range 1..15.
- TICK_DIV, 1: clock cycles per mtime increment. Legal range 1..65535.
- BASE_ADDR, 32'h1001_0000: base of the two-word register window.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  32  read address
- arid  in  4  read transaction id
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  32  read data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rid  out  4  echoed arid
- rlast  out  1  always 1 with rvalid (single-beat)
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  32  write address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response code

Behaviour:
- Reset (rst_n=0, async): mtime=0, prescaler=0, read FSM=R_IDLE, write FSM=W_IDLE. rvalid, bvalid, rlast=0; rdata, rid=0; rresp, bresp=00. Any in-flight transaction is dropped with no response.
- mtime: the prescaler counts 0..TICK_DIV-1. mtime += 1 in the cycle the prescaler wraps. A carry from low 0xFFFF_FFFF propagates into the high word. Full 64-bit wrap to 0 is silent.
- Read FSM, states R_IDLE -> R_WAIT -> R_RESP:
  - arready = (state==R_IDLE).
  - On AR handshake: latch arid, decode araddr, snapshot the addressed mtime word as it was before this cycle's update.
  - Decode: BASE -> mtime[31:0]; BASE+4 -> mtime[63:32]; any other address -> rdata=0, rresp=11.
  - R_WAIT counts RD_LAT-1 cycles; with RD_LAT=1 it goes straight to R_RESP the next cycle.
  - R_RESP: rvalid=1, rlast=1, rid=latched id; data, id and resp are held stable until rready. On handshake, return to R_IDLE. A new AR is accepted the cycle after.
- Write FSM, states W_IDLE -> W_RESP:
  - AW and W are accepted independently in W_IDLE. awready=!aw_got, wready=!w_got.
  - Once both are captured (same or different cycles): perform the write and enter W_RESP with bvalid=1.
  - bvalid is held until bready, then return to W_IDLE and clear aw_got/w_got.
  - No AW/W is accepted while in W_RESP.
- Write effect: see Optional Feature. Out-of-window awaddr -> bresp=11, no state change.
- Read and write FSMs run concurrently.
  - A write and a tick in the same cycle: the write wins and the tick is lost.
  - A write and an AR handshake in the same cycle: the read returns the pre-write value.

Optional Feature:
- Macro CLINT_MTIME_WRITE_EN.
- Defined: an in-window write updates the selected mtime word byte-wise per wstrb, with bresp=00. The prescaler resets to 0 on any mtime write. wstrb=0 leaves mtime unchanged but still returns bresp=00.
- Undefined: mtime is read-only. In-window writes return bresp=10 (SLVERR) and mtime and the prescaler are untouched.

Decomposition:
- Shared package ysyx_25040109_bus_pkg holds:
  - RESP_OKAY/SLVERR/DECERR
  - CLINT_LO_ADDR/CLINT_HI_ADDR
  - id width (4)
  - the crossbar uses the same constants.
- Sub-module ysyx_25040109_clint_mtime: prescaler, 64-bit counter with carry, byte-strobe write port, and snapshot outputs.

Test Plan:
- Reset, then idle 10 cycles (TICK_DIV=1); AR 0x1001_0000, arid=4'h5 -> rvalid RD_LAT cycles later with rdata=10 (±0 exactly per snapshot), rid=5, rlast=1, rresp=00.
- mtime forced to 0x0000_0000_FFFF_FFFF (feature on), 1 tick -> AR 0x1001_0004 returns 1, AR 0x1001_0000 returns 0.
- AR 0x1001_0008 -> rdata=0, rresp=11. AW 0x2000_0000 -> bresp=11, mtime unaffected.
- W before AW by 3 cycles, then AW 0x1001_0000, wdata=0xAABB_CCDD, wstrb=4'b0011 (feature on) -> bvalid, bresp=00, low word = {old[31:16], 16'hCCDD}. Same sequence with feature off -> bresp=10, no change.
- rready held low 5 cycles -> rvalid, rdata, rid stable. arready=0 throughout, so a second AR is stalled.
- rst_n pulled low while in R_RESP -> rvalid=0 immediately (async). After release, arready=1 and mtime=0.

Source files
------------

// File: rtl/ysyx_25040109_bus_pkg.sv
// Bus-wide constants shared by the crossbar and the CLINT: response codes,
// CLINT register addresses, id width, plus the CLINT FSM state types.
package ysyx_25040109_bus_pkg;

  localparam int unsigned ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] CLINT_LO_ADDR = 32'h1001_0000;
  localparam logic [31:0] CLINT_HI_ADDR = 32'h1001_0004;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_25040109_clint_mtime.sv
// Free-running 64-bit mtime with a TICK_DIV prescaler and a byte-strobed
// word write port; a write pre-empts the tick of the same cycle.
module ysyx_25040109_clint_mtime
  import ysyx_25040109_bus_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [31:0] mtime_lo,
  output logic [31:0] mtime_hi
);

  logic [15:0] pre;
  logic [63:0] mtime;
  logic        tick;

  assign tick     = (pre == 16'(TICK_DIV - 1));
  assign mtime_lo = mtime[31:0];
  assign mtime_hi = mtime[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      mtime <= '0;
    end else if (wr_en) begin
      pre <= '0;
      if (wr_hi) mtime[63:32] <= strb_merge(mtime[63:32], wr_data, wr_strb);
      else       mtime[31:0]  <= strb_merge(mtime[31:0],  wr_data, wr_strb);
    end else if (tick) begin
      pre   <= '0;
      mtime <= mtime + 64'd1;
    end else begin
      pre <= pre + 16'd1;
    end
  end

endmodule

// File: rtl/ysyx_25040109_clint.sv
// CLINT AXI responder: single-beat reads of mtime lo/hi, write responses.
// Macro CLINT_MTIME_WRITE_EN makes mtime writable; otherwise writes get SLVERR.
module ysyx_25040109_clint
  import ysyx_25040109_bus_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [31:0] BASE_ADDR = CLINT_LO_ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arvalid,
  output logic            arready,
  input  logic [31:0]     araddr,
  input  logic [ID_W-1:0] arid,
  output logic            rvalid,
  input  logic            rready,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic [ID_W-1:0] rid,
  output logic            rlast,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     awaddr,
  input  logic            wvalid,
  output logic            wready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp
);

  localparam logic [31:0] HI_ADDR = BASE_ADDR + 32'd4;

  logic [31:0] mtime_lo, mtime_hi;

  // ---------------- read channel ----------------
  rd_state_e r_state, r_next;
  logic [3:0] r_cnt;
  logic       ar_fire;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign rlast   = rvalid;
  assign ar_fire = arvalid & arready;

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_fire) r_next = (RD_LAT <= 1) ? R_RESP : R_WAIT;
      R_WAIT: if (r_cnt <= 4'd1) r_next = R_RESP;
      R_RESP: if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= r_next;
      if (ar_fire)                r_cnt <= 4'(RD_LAT - 1);
      else if (r_state == R_WAIT) r_cnt <= r_cnt - 4'd1;
    end
  end

  // mtime registers still hold the pre-update value here, so the snapshot
  // ignores any tick or write landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      rid   <= '0;
      rresp <= RESP_OKAY;
    end else if (ar_fire) begin
      rid <= arid;
      if (araddr == BASE_ADDR) begin
        rdata <= mtime_lo;
        rresp <= RESP_OKAY;
      end else if (araddr == HI_ADDR) begin
        rdata <= mtime_hi;
        rresp <= RESP_OKAY;
      end else begin
        rdata <= '0;
        rresp <= RESP_DECERR;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_e   w_state, w_next;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_fire, w_fire, b_fire, wr_fire;
  logic [31:0] addr_eff, data_eff;
  logic [3:0]  strb_eff;
  logic        in_win, sel_hi, mt_wr_en;
  logic [1:0]  resp_code;

  assign awready = (w_state == W_IDLE) & ~aw_got;
  assign wready  = (w_state == W_IDLE) & ~w_got;
  assign bvalid  = (w_state == W_RESP);
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign b_fire  = bvalid & bready;

  // The completing half may arrive this cycle, so bypass its register.
  assign addr_eff = aw_got ? aw_addr_q : awaddr;
  assign data_eff = w_got  ? w_data_q  : wdata;
  assign strb_eff = w_got  ? w_strb_q  : wstrb;
  assign wr_fire  = (w_state == W_IDLE) & (aw_got | aw_fire) & (w_got | w_fire);
  assign sel_hi   = (addr_eff == HI_ADDR);
  assign in_win   = (addr_eff == BASE_ADDR) | sel_hi;

`ifdef CLINT_MTIME_WRITE_EN
  assign mt_wr_en  = wr_fire & in_win;
  assign resp_code = in_win ? RESP_OKAY : RESP_DECERR;
`else
  assign mt_wr_en  = 1'b0;
  assign resp_code = in_win ? RESP_SLVERR : RESP_DECERR;
`endif

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (wr_fire) w_next = W_RESP;
      W_RESP:  if (bready)  w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (b_fire) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_fire) aw_got <= 1'b1;
        if (w_fire)  w_got  <= 1'b1;
      end
      if (aw_fire) aw_addr_q <= awaddr;
      if (w_fire) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (wr_fire) bresp <= resp_code;
    end
  end

  ysyx_25040109_clint_mtime #(
    .TICK_DIV(TICK_DIV)
  ) u_mtime (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (mt_wr_en),
    .wr_hi    (sel_hi),
    .wr_data  (data_eff),
    .wr_strb  (strb_eff),
    .mtime_lo (mtime_lo),
    .mtime_hi (mtime_hi)
  );

endmodule

// File: tb/tb_ysyx_25040109_clint.sv
// Self-checking bench for ysyx_25040109_clint; mtime is modelled as
// base value plus elapsed cycles divided by TICK_DIV.
module tb_ysyx_25040109_clint;

  localparam int unsigned RD_LAT   = 3;
  localparam int unsigned TICK_DIV = 1;
  localparam logic [31:0] BASE     = 32'h1001_0000;
  localparam logic [31:0] HI       = 32'h1001_0004;
`ifdef CLINT_MTIME_WRITE_EN
  localparam logic [1:0]  RESP_IN  = 2'b00;
`else
  localparam logic [1:0]  RESP_IN  = 2'b10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [3:0]  arid = '0, wstrb = '0;
  logic        arready, rvalid, rlast, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [3:0]  rid;

  int checks = 0;
  int errors = 0;

  logic [63:0] cyc;
  logic [63:0] base_val = '0;
  logic [63:0] base_cyc = '0;

  ysyx_25040109_clint #(
    .RD_LAT(RD_LAT), .TICK_DIV(TICK_DIV), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; edge n leaves mtime == exp_mtime(n).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 64'd1;
  end

  function automatic logic [63:0] exp_mtime(input logic [63:0] n);
    return base_val + (n - base_cyc) / 64'(TICK_DIV);
  endfunction

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                         input int unsigned stall, input bit poke);
    logic [63:0] h, v;
    logic [31:0] ed;
    logic [1:0]  er;
    int unsigned lat;
    @(negedge clk);
    araddr = addr; arid = id; arvalid = 1'b1;
    checks++;
    if (arready !== 1'b1) begin
      errors++; $display("FAIL ar_accept: arready=%b want 1", arready);
    end
    h = cyc + 64'd1;
    v = exp_mtime(h - 64'd1);
    if (addr == BASE)    begin ed = v[31:0];  er = 2'b00; end
    else if (addr == HI) begin ed = v[63:32]; er = 2'b00; end
    else                 begin ed = '0;       er = 2'b11; end
    @(negedge clk);
    arvalid = 1'b0; araddr = $urandom; arid = 4'($urandom);
    lat = 1;
    while (rvalid !== 1'b1 && lat < RD_LAT + 8) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (lat != RD_LAT || rvalid !== 1'b1) begin
      errors++; $display("FAIL rd_latency: got %0d cycles (rvalid=%b) want %0d", lat, rvalid, RD_LAT);
    end
    checks++;
    if (rdata !== ed) begin
      errors++; $display("FAIL rd_data @%h: got %h want %h", addr, rdata, ed);
    end
    checks++;
    if (rid !== id) begin
      errors++; $display("FAIL rd_id: got %h want %h", rid, id);
    end
    checks++;
    if (rresp !== er) begin
      errors++; $display("FAIL rd_resp @%h: got %b want %b", addr, rresp, er);
    end
    checks++;
    if (rlast !== 1'b1) begin
      errors++; $display("FAIL rd_last: got %b want 1", rlast);
    end
    if (poke) begin arvalid = 1'b1; araddr = BASE; end
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== ed || rid !== id || rresp !== er || arready !== 1'b0) begin
        errors++;
        $display("FAIL rd_hold: got v=%b d=%h id=%h r=%b ar=%b want v=1 d=%h id=%h r=%b ar=0",
                 rvalid, rdata, rid, rresp, arready, ed, id, er);
      end
    end
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL rd_done: got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int unsigned gap,
                          input int unsigned bdelay);
    logic [63:0] e, v;
    logic [1:0]  er;
    bit          hit;
    @(negedge clk);
    wdata = data; wstrb = strb; wvalid = 1'b1;
    if (gap == 0) begin awaddr = addr; awvalid = 1'b1; end
    checks++;
    if (wready !== 1'b1 || awready !== 1'b1) begin
      errors++; $display("FAIL wr_accept: wready=%b awready=%b want 1 1", wready, awready);
    end
    if (gap != 0) begin
      @(negedge clk);
      wvalid = 1'b0; wdata = $urandom; wstrb = 4'($urandom);
      for (int unsigned i = 1; i < gap; i++) @(negedge clk);
      awaddr = addr; awvalid = 1'b1;
      checks++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
        errors++;
        $display("FAIL wr_w_held: wready=%b awready=%b bvalid=%b want 0 1 0", wready, awready, bvalid);
      end
    end
    e = cyc + 64'd1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; awaddr = $urandom; wdata = $urandom;
    v   = exp_mtime(e - 64'd1);
    hit = (addr == BASE) || (addr == HI);
    er  = hit ? RESP_IN : 2'b11;
`ifdef CLINT_MTIME_WRITE_EN
    if (hit) begin
      logic [31:0] w;
      w = (addr == HI) ? v[63:32] : v[31:0];
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      if (addr == HI) v[63:32] = w; else v[31:0] = w;
      base_val = v;
      base_cyc = e;
    end
`endif
    checks++;
    if (bvalid !== 1'b1 || bresp !== er) begin
      errors++; $display("FAIL wr_bresp @%h: got bvalid=%b bresp=%b want 1 %b", addr, bvalid, bresp, er);
    end
    awvalid = 1'b1; wvalid = 1'b1; awaddr = BASE;
    for (int unsigned i = 0; i < bdelay; i++) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== er || awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL wr_hold: got b=%b r=%b aw=%b w=%b want 1 %b 0 0", bvalid, bresp, awready, wready, er);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL wr_done: got b=%b aw=%b w=%b want 0 1 1", bvalid, awready, wready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'd0 ||
        rid !== 4'd0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_out: rv=%b bv=%b rl=%b rd=%h id=%h rr=%b br=%b want all 0",
               rvalid, bvalid, rlast, rdata, rid, rresp, bresp);
    end
    checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ar=%b aw=%b w=%b want 1 1 1", arready, awready, wready);
    end
  endtask

  task automatic test_count();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    do_read(BASE, 4'h5, 0, 1'b0);
  endtask

  task automatic test_carry();
    do_write(HI, 32'h0, 4'hF, 0, 0);
    do_write(BASE, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_read(HI, 4'h1, 0, 1'b0);
    do_read(BASE, 4'h2, 0, 1'b0);
  endtask

  task automatic test_decode();
    do_read(BASE + 32'd8, 4'h3, 1, 1'b0);
    do_write(32'h2000_0000, 32'h1234_5678, 4'hF, 0, 1);
    do_read(BASE, 4'h4, 0, 1'b0);
  endtask

  task automatic test_write_w_first();
    do_write(BASE, 32'hAABB_CCDD, 4'b0011, 3, 1);
    do_read(BASE, 4'h6, 0, 1'b0);
    do_write(HI, 32'h5555_AAAA, 4'b0000, 2, 0);
    do_read(HI, 4'h8, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_read(HI, 4'h7, 5, 1'b1);
  endtask

  task automatic test_same_cycle();
    logic [63:0] e, v;
    logic [31:0] d;
    int unsigned lat;
    d = $urandom;
    @(negedge clk);
    araddr = BASE; arid = 4'hA; arvalid = 1'b1;
    awaddr = BASE; awvalid = 1'b1; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    e = cyc + 64'd1;
    v = exp_mtime(e - 64'd1);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
`ifdef CLINT_MTIME_WRITE_EN
    base_val = {v[63:32], d};
    base_cyc = e;
`endif
    checks++;
    if (bvalid !== 1'b1 || bresp !== RESP_IN) begin
      errors++; $display("FAIL same_bresp: got bvalid=%b bresp=%b want 1 %b", bvalid, bresp, RESP_IN);
    end
    bready = 1'b1;
    lat = 1;
    while (rvalid !== 1'b1 && lat < RD_LAT + 8) begin
      @(negedge clk); bready = 1'b0; lat++;
    end
    bready = 1'b0;
    checks++;
    if (lat != RD_LAT || rdata !== v[31:0] || rid !== 4'hA || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL same_read: got lat=%0d d=%h id=%h bv=%b want %0d %h a 0",
               lat, rdata, rid, bvalid, RD_LAT, v[31:0]);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    do_read(BASE, 4'hB, 0, 1'b0);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return BASE;
      1:       return HI;
      2:       return BASE + 32'd8;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(pick_addr(), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(pick_addr(), 4'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  task automatic test_async_reset();
    int unsigned lat;
    @(negedge clk);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    araddr = HI; arid = 4'h9; arvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; arvalid = 1'b0;
    lat = 1;
    while (rvalid !== 1'b1 && lat < RD_LAT + 8) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (rvalid !== 1'b1 || wready !== 1'b0) begin
      errors++; $display("FAIL pre_reset: rvalid=%b wready=%b want 1 0", rvalid, wready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'd0 || rid !== 4'd0 ||
        rresp !== 2'b00 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rv=%b rl=%b rd=%h id=%h rr=%b bv=%b want all 0",
               rvalid, rlast, rdata, rid, rresp, bvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base_val = '0;
    base_cyc = '0;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL post_reset: ar=%b aw=%b w=%b want 1 1 1", arready, awready, wready);
    end
    repeat (3) @(negedge clk);
    do_read(BASE, 4'hC, 0, 1'b0);
    do_read(HI, 4'hD, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_count();
    test_carry();
    test_decode();
    test_write_w_first();
    test_stall();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion before 200000");
    $fatal(1);
  end

endmodule
